// File: rtl/mmio_uart_ctrl_pkg.sv
// Shared definitions for the MMIO UART controller: register offsets, STATUS layout
// and the helper that assembles the STATUS word.
package mmio_uart_ctrl_pkg;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CNTRST = 8'h18;

  localparam int ST_TX_READY   = 0;
  localparam int ST_RX_AVAIL   = 1;
  localparam int ST_TX_OVF     = 2;
  localparam int ST_RX_LVL_LSB = 8;
  localparam int ST_TX_LVL_LSB = 16;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_STATUS,
    SEL_RXDATA,
    SEL_TXDATA,
    SEL_CYCLE,
    SEL_INSTR,
    SEL_CNTRST
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [7:0] off);
    case (off)
      OFF_STATUS: return SEL_STATUS;
      OFF_RXDATA: return SEL_RXDATA;
      OFF_TXDATA: return SEL_TXDATA;
      OFF_CYCLE:  return SEL_CYCLE;
      OFF_INSTR:  return SEL_INSTR;
      OFF_CNTRST: return SEL_CNTRST;
      default:    return SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] status_word(input logic tx_full, input logic rx_empty,
                                              input logic tx_ovf, input logic [7:0] rx_lvl,
                                              input logic [7:0] tx_lvl);
    logic [31:0] w;
    w = '0;
    w[ST_TX_READY] = !tx_full;
    w[ST_RX_AVAIL] = !rx_empty;
    w[ST_TX_OVF]   = tx_ovf;
    w[ST_RX_LVL_LSB +: 8] = rx_lvl;
    w[ST_TX_LVL_LSB +: 8] = tx_lvl;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// CPU-side memory-mapped bus between the datapath (master) and the I/O controller (slave).
interface mmio_uart_ctrl_if;
  logic [31:0] addr;
  logic [3:0]  we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;

  modport master (output addr, we, re, wdata, stall, input rdata);
  modport slave  (input addr, we, re, wdata, stall, output rdata);
endinterface

// File: rtl/mmio_uart_ctrl_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; push and pop may coincide.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [7:0]       level
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign level   = 8'(count_reg);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head is forced to zero when empty so consumers never see stale storage.
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
    end
  end
endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO controller bridging the CPU bus to the UART byte streams, with TX/RX FIFOs,
// a sticky TX overflow flag and cycle / retired-instruction counters.
module mmio_uart_ctrl
  import mmio_uart_ctrl_pkg::*;
#(
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  mmio_uart_ctrl_if.slave   bus,
  input  logic              inst_retire,
  output logic [7:0]        uart_din,
  output logic              uart_din_valid,
  input  logic              uart_din_ready,
  input  logic [7:0]        uart_dout,
  input  logic              uart_dout_valid,
  output logic              uart_dout_ready
);
  logic             hit, acc, wr_acc, rd_acc;
  reg_sel_e         sel;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]       tx_level, rx_level, rx_head;
  logic             tx_push, rx_pop, cnt_clr;
  logic             tx_ovf_reg;
  logic [CNT_W-1:0] cycle_reg, instr_reg;
  logic [31:0]      rdata_reg, rdata_next;
  logic             unused_wdata;

  assign unused_wdata = ^bus.wdata[31:8];

  assign hit    = (bus.addr[31:8] == BASE_ADDR[31:8]);
  assign acc    = hit && !bus.stall;
  assign wr_acc = acc && (|bus.we);
  assign rd_acc = acc && bus.re;
  assign sel    = decode_offset(bus.addr[7:0]);

  // The full flag is registered FIFO state, so a drain on the same edge cannot rescue the write.
  assign tx_push = wr_acc && (sel == SEL_TXDATA) && !tx_full;
  assign rx_pop  = rd_acc && (sel == SEL_RXDATA) && !rx_empty;
  assign cnt_clr = wr_acc && (sel == SEL_CNTRST);

  assign uart_din_valid  = !tx_empty;
  assign uart_dout_ready = !rx_full;
  assign bus.rdata       = rdata_reg;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (bus.wdata[7:0]),
    .pop   (uart_din_valid && uart_din_ready),
    .dout  (uart_din),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_dout_valid && uart_dout_ready),
    .din   (uart_dout),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  always_comb begin
    rdata_next = '0;
    if (hit) begin
      case (sel)
        SEL_STATUS: rdata_next = status_word(tx_full, rx_empty, tx_ovf_reg, rx_level, tx_level);
        SEL_RXDATA: rdata_next = {24'b0, rx_head};
        SEL_CYCLE:  rdata_next = 32'(cycle_reg);
        SEL_INSTR:  rdata_next = 32'(instr_reg);
        default:    rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg  <= '0;
      tx_ovf_reg <= 1'b0;
      cycle_reg  <= '0;
      instr_reg  <= '0;
    end else begin
      // Misses still complete as reads returning zero; only a stall holds rdata.
      if (bus.re && !bus.stall) rdata_reg <= rdata_next;

      if (wr_acc && (sel == SEL_TXDATA) && tx_full) tx_ovf_reg <= 1'b1;
      else if (wr_acc && (sel == SEL_STATUS))       tx_ovf_reg <= 1'b0;

      if (cnt_clr) begin
        cycle_reg <= '0;
        instr_reg <= '0;
      end else begin
        cycle_reg <= cycle_reg + CNT_W'(1);
        if (inst_retire && !bus.stall) instr_reg <= instr_reg + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl: a vector table for single accesses, then
// hand-written sequences for FIFO, overflow, stall and counter corner cases.
module tb_mmio_uart_ctrl;
  logic       clk, rst;
  logic       inst_retire;
  logic [7:0] uart_din, uart_dout;
  logic       uart_din_valid, uart_din_ready, uart_dout_valid, uart_dout_ready;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] B = 32'h8000_0000;

  mmio_uart_ctrl_if bus();

  mmio_uart_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8), .CNT_W(32), .BASE_ADDR(B)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .inst_retire     (inst_retire),
    .uart_din        (uart_din),
    .uart_din_valid  (uart_din_valid),
    .uart_din_ready  (uart_din_ready),
    .uart_dout       (uart_dout),
    .uart_dout_valid (uart_dout_valid),
    .uart_dout_ready (uart_dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 4'hF;
    @(posedge clk); #1;
    bus.we = 4'h0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] v);
    bus.addr = a; bus.re = 1'b1;
    @(posedge clk); #1;
    bus.re = 1'b0;
    v = bus.rdata;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    cpu_read(a, v);
    check(name, v, exp);
  endtask

  task automatic drain_check(input string name, input int n, input logic [7:0] first);
    uart_din_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({name, "_valid"}, 32'(uart_din_valid), 32'd1);
      check({name, "_byte"}, 32'(uart_din), 32'(first + 8'(i)));
      @(posedge clk); #1;
    end
    check({name, "_empty"}, 32'(uart_din_valid), 32'd0);
    uart_din_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; inst_retire = 1'b0;
    bus.addr = '0; bus.we = '0; bus.re = 1'b0; bus.wdata = '0; bus.stall = 1'b0;
    uart_din_ready = 1'b0; uart_dout = '0; uart_dout_valid = 1'b0;

    vecs[0]  = '{1'b0, B + 32'h00, 32'h0,  32'h0000_0001, "reset_status"};
    vecs[1]  = '{1'b1, B + 32'h08, 32'h41, 32'h0,         "tx_w41"};
    vecs[2]  = '{1'b1, B + 32'h08, 32'h42, 32'h0,         "tx_w42"};
    vecs[3]  = '{1'b1, B + 32'h08, 32'h43, 32'h0,         "tx_w43"};
    vecs[4]  = '{1'b0, B + 32'h00, 32'h0,  32'h0003_0001, "status_tx3"};
    vecs[5]  = '{1'b0, B + 32'h0C, 32'h0,  32'h0,         "unmapped_rd"};
    vecs[6]  = '{1'b0, B + 32'h00, 32'h0,  32'h0003_0001, "status_again"};
    vecs[7]  = '{1'b0, 32'h9000_0000, 32'h0, 32'h0,       "miss_rd"};
    vecs[8]  = '{1'b0, B + 32'h04, 32'h0,  32'h0,         "rx_empty_rd"};
    vecs[9]  = '{1'b1, 32'h9000_0008, 32'h77, 32'h0,      "miss_wr"};
    vecs[10] = '{1'b1, B + 32'h20, 32'h55, 32'h0,         "unmapped_wr"};
    vecs[11] = '{1'b0, B + 32'h00, 32'h0,  32'h0003_0001, "status_unchanged"};

    #23 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_din_valid", 32'(uart_din_valid), 32'd0);
    check("reset_dout_ready", 32'(uart_dout_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) cpu_write(vecs[i].addr, vecs[i].wdata);
      else read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    drain_check("tx_order", 3, 8'h41);

    // Overflow: eight fill the FIFO, the ninth is dropped and flagged.
    for (int i = 0; i < 8; i++) cpu_write(B + 32'h08, 32'(8'h10 + 8'(i)));
    cpu_write(B + 32'h08, 32'h99);
    read_check("status_ovf", B + 32'h00, 32'h0008_0004);
    cpu_write(B + 32'h00, 32'h0);
    read_check("status_ovf_clr", B + 32'h00, 32'h0008_0000);
    drain_check("tx_fill", 8, 8'h10);

    // RX backpressure: nine bytes offered into eight entries.
    for (int i = 0; i < 8; i++) begin
      uart_dout = 8'hA0 + 8'(i); uart_dout_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("rx_full_ready", 32'(uart_dout_ready), 32'd0);
    uart_dout = 8'hA8;
    read_check("status_rx8", B + 32'h00, 32'h0000_0803);
    read_check("rx_rd0", B + 32'h04, 32'h0000_00A0);
    check("rx_ready_after_pop", 32'(uart_dout_ready), 32'd1);
    @(posedge clk); #1;
    uart_dout_valid = 1'b0;
    check("rx_refull_ready", 32'(uart_dout_ready), 32'd0);
    for (int i = 1; i <= 8; i++) read_check("rx_rd", B + 32'h04, 32'(8'hA0 + 8'(i)));
    read_check("rx_drained_rd", B + 32'h04, 32'h0);
    read_check("status_rx0", B + 32'h00, 32'h0000_0001);

    // Stalled RXDATA read must not pop and must hold rdata.
    for (int i = 0; i < 2; i++) begin
      uart_dout = (i == 0) ? 8'h55 : 8'h66; uart_dout_valid = 1'b1;
      @(posedge clk); #1;
    end
    uart_dout_valid = 1'b0;
    read_check("status_rx2", B + 32'h00, 32'h0000_0203);
    bus.addr = B + 32'h04; bus.re = 1'b1; bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_hold", bus.rdata, 32'h0000_0203);
    end
    bus.stall = 1'b0;
    @(posedge clk); #1;
    bus.re = 1'b0;
    check("post_stall_pop", bus.rdata, 32'h0000_0055);
    read_check("status_rx1", B + 32'h00, 32'h0000_0103);
    read_check("rx_rd_66", B + 32'h04, 32'h0000_0066);

    // Counters: ten retires, two of them stalled.
    cpu_write(B + 32'h18, 32'h0);
    for (int i = 0; i < 10; i++) begin
      inst_retire = 1'b1; bus.stall = (i == 3 || i == 4);
      @(posedge clk); #1;
    end
    inst_retire = 1'b0; bus.stall = 1'b0;
    read_check("instr_8", B + 32'h14, 32'd8);
    bus.addr = B + 32'h18; bus.we = 4'hF; inst_retire = 1'b1;
    @(posedge clk); #1;
    bus.we = 4'h0; inst_retire = 1'b0;
    read_check("cycle_after_clr", B + 32'h10, 32'd0);
    read_check("instr_after_clr", B + 32'h14, 32'd0);
    read_check("cycle_counting", B + 32'h10, 32'd2);

    // Asynchronous reset in the middle of a pending TX byte.
    cpu_write(B + 32'h08, 32'h5A);
    check("pre_rst_din", 32'(uart_din), 32'h5A);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(uart_din_valid), 32'd0);
    check("async_rst_din", 32'(uart_din), 32'd0);
    check("async_rst_ready", 32'(uart_dout_ready), 32'd1);
    check("async_rst_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    read_check("post_rst_status", B + 32'h00, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
